// File: rtl/packet_parser_pkg.sv
// Shared types and width helpers for the packet parser front end.
package packet_parser_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width of the gap counter. Large enough for gaps of up to 15 cycles.
    localparam int GAP_W = 4;

    // Width of a Mod field: the number of bits needed to count bytes in one bus word.
    function automatic int mod_w(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 1;
    endfunction

    // Width of a port index. Never narrower than one bit.
    function automatic int port_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr+1 (mod N), so the port that was served last has the
// lowest priority. Returns a one-hot grant and its encoded index.
module rr_arbiter
    import packet_parser_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [port_w(N)-1:0]   ptr,
    output logic [N-1:0]           grant,
    output logic [port_w(N)-1:0]   idx,
    output logic                   any
);

    localparam int PW = port_w(N);

    int            cand;
    logic [PW-1:0] cand_idx;

    // Walk the ports in rotated order and take the first requester found.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = PW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/packet_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the packet parser input bus.
// Pops whole packets (Sop..Eop) from one FWFT source at a time and forwards
// them on a registered push bus. An idle gap follows every Eop.
module packet_input_arbiter
    import packet_parser_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                                    Clk,
    input  logic                                    Rst,
    input  logic [NUM_PORTS-1:0]                    Src_DataValid,
    input  logic [NUM_PORTS-1:0]                    Src_DataSop,
    input  logic [NUM_PORTS-1:0]                    Src_DataEop,
    input  logic [NUM_PORTS*mod_w(DATA_WIDTH)-1:0]  Src_Mod,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]         Src_Data,
    output logic [NUM_PORTS-1:0]                    Src_DataRead,
    output logic                                    OutBus_DataValid,
    output logic                                    OutBus_DataSop,
    output logic                                    OutBus_DataEop,
    output logic [mod_w(DATA_WIDTH)-1:0]            OutBus_Mod,
    output logic [DATA_WIDTH-1:0]                   OutBus_Data,
    output logic [port_w(NUM_PORTS)-1:0]            OutBus_Port,
    output logic                                    Busy,
    output logic                                    Err_NoSop,
    output logic                                    Err_MidSop
);

    localparam int MOD_W = mod_w(DATA_WIDTH);
    localparam int PORT_W = port_w(NUM_PORTS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state_reg;
    logic [PORT_W-1:0]     rr_ptr_reg;
    logic [PORT_W-1:0]     grant_reg;
    logic [NUM_PORTS-1:0]  grant_oh_reg;
    logic                  first_word_reg;
    logic [GAP_W-1:0]      gap_cnt_reg;

    logic [NUM_PORTS-1:0]  arb_grant;
    logic [PORT_W-1:0]     arb_idx;
    logic                  arb_any;

    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];
    logic [MOD_W-1:0]      mod_arr  [NUM_PORTS];

    logic                  head_valid;
    logic                  head_sop;
    logic                  head_eop;
    logic [MOD_W-1:0]      head_mod;
    logic [DATA_WIDTH-1:0] head_data;

    // Unpack the flat per-port buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
            assign data_arr[gi] = Src_Data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign mod_arr[gi]  = Src_Mod[gi*MOD_W +: MOD_W];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .req   (Src_DataValid),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Head word of the currently granted source.
    assign head_valid = Src_DataValid[grant_reg];
    assign head_sop   = Src_DataSop[grant_reg];
    assign head_eop   = Src_DataEop[grant_reg];
    assign head_mod   = mod_arr[grant_reg];
    assign head_data  = data_arr[grant_reg];

    assign Busy = (state_reg != IDLE);

    // Pop the granted FWFT source whenever it shows a word during a transfer.
    // This must be combinational: the head word is consumed in the same cycle
    // it is seen, which is what gives one word per cycle.
    always_comb begin
        Src_DataRead = '0;
        if (state_reg == XFER) begin
            Src_DataRead = grant_oh_reg & Src_DataValid;
        end
    end

    // Arbitration FSM, gap counter and registered output bus.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= PORT_W'(NUM_PORTS - 1);
            grant_reg        <= '0;
            grant_oh_reg     <= '0;
            first_word_reg   <= 1'b0;
            gap_cnt_reg      <= '0;
            OutBus_DataValid <= 1'b0;
            OutBus_DataSop   <= 1'b0;
            OutBus_DataEop   <= 1'b0;
            OutBus_Mod       <= '0;
            OutBus_Data      <= '0;
            OutBus_Port      <= '0;
            Err_NoSop        <= 1'b0;
            Err_MidSop       <= 1'b0;
        end else begin
            // Strobes default low; data and port hold their last value.
            OutBus_DataValid <= 1'b0;
            OutBus_DataSop   <= 1'b0;
            OutBus_DataEop   <= 1'b0;
            OutBus_Mod       <= '0;
            Err_NoSop        <= 1'b0;
            Err_MidSop       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        grant_reg      <= arb_idx;
                        grant_oh_reg   <= arb_grant;
                        rr_ptr_reg     <= arb_idx;
                        first_word_reg <= 1'b1;
                        state_reg      <= XFER;
                    end
                end

                XFER: begin
                    // An underrun simply leaves us here with nothing popped.
                    if (head_valid) begin
                        first_word_reg <= 1'b0;
                        if (first_word_reg && !head_sop) begin
                            // Orphan word (e.g. stale tail after reset): drop it.
                            Err_NoSop <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            OutBus_DataValid <= 1'b1;
                            OutBus_DataSop   <= head_sop;
                            OutBus_DataEop   <= head_eop;
                            OutBus_Mod       <= head_eop ? head_mod : '0;
                            OutBus_Data      <= head_data;
                            OutBus_Port      <= grant_reg;
                            Err_MidSop       <= head_sop && !first_word_reg;
                            if (head_eop) begin
                                if (GAP_CYCLES > 0) begin
                                    gap_cnt_reg <= '0;
                                    state_reg   <= GAP;
                                end else begin
                                    state_reg   <= IDLE;
                                end
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_input_arbiter.sv
// Scoreboard bench for packet_input_arbiter: FWFT source models feed the DUT,
// expected words are queued by each test, and a monitor checks every output word.
module tb_packet_input_arbiter;

    localparam int DW = 64;
    localparam int NP = 4;
    localparam int MW = 3;
    localparam int PW = 2;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [MW-1:0] mod;
        logic [DW-1:0] data;
        logic [7:0]    gap;
    } src_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [MW-1:0] mod;
        logic [DW-1:0] data;
        logic [PW-1:0] port;
        logic          midsop;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [NP-1:0]    Src_DataValid = '0;
    logic [NP-1:0]    Src_DataSop = '0;
    logic [NP-1:0]    Src_DataEop = '0;
    logic [NP*MW-1:0] Src_Mod = '0;
    logic [NP*DW-1:0] Src_Data = '0;

    // Outputs of the GAP_CYCLES=1 instance (a_*) and the GAP_CYCLES=0 instance (g_*).
    logic [NP-1:0] a_rd, g_rd;
    logic a_valid, a_sop, a_eop, a_busy, a_nosop, a_midsop;
    logic g_valid, g_sop, g_eop, g_busy, g_nosop, g_midsop;
    logic [MW-1:0] a_mod, g_mod;
    logic [DW-1:0] a_data, g_data;
    logic [PW-1:0] a_port, g_port;

    packet_input_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_CYCLES(1)) dut (
        .Clk(Clk), .Rst(Rst),
        .Src_DataValid(Src_DataValid), .Src_DataSop(Src_DataSop), .Src_DataEop(Src_DataEop),
        .Src_Mod(Src_Mod), .Src_Data(Src_Data), .Src_DataRead(a_rd),
        .OutBus_DataValid(a_valid), .OutBus_DataSop(a_sop), .OutBus_DataEop(a_eop),
        .OutBus_Mod(a_mod), .OutBus_Data(a_data), .OutBus_Port(a_port),
        .Busy(a_busy), .Err_NoSop(a_nosop), .Err_MidSop(a_midsop)
    );

    packet_input_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_CYCLES(0)) dut_gap0 (
        .Clk(Clk), .Rst(Rst),
        .Src_DataValid(Src_DataValid), .Src_DataSop(Src_DataSop), .Src_DataEop(Src_DataEop),
        .Src_Mod(Src_Mod), .Src_Data(Src_Data), .Src_DataRead(g_rd),
        .OutBus_DataValid(g_valid), .OutBus_DataSop(g_sop), .OutBus_DataEop(g_eop),
        .OutBus_Mod(g_mod), .OutBus_Data(g_data), .OutBus_Port(g_port),
        .Busy(g_busy), .Err_NoSop(g_nosop), .Err_MidSop(g_midsop)
    );

    // sel chooses which instance the source models and the monitor are attached to.
    bit sel = 1'b0;
    logic [NP-1:0] m_rd;
    logic m_valid, m_sop, m_eop, m_busy, m_nosop, m_midsop;
    logic [MW-1:0] m_mod;
    logic [DW-1:0] m_data;
    logic [PW-1:0] m_port;
    assign m_rd     = sel ? g_rd     : a_rd;
    assign m_valid  = sel ? g_valid  : a_valid;
    assign m_sop    = sel ? g_sop    : a_sop;
    assign m_eop    = sel ? g_eop    : a_eop;
    assign m_mod    = sel ? g_mod    : a_mod;
    assign m_data   = sel ? g_data   : a_data;
    assign m_port   = sel ? g_port   : a_port;
    assign m_busy   = sel ? g_busy   : a_busy;
    assign m_nosop  = sel ? g_nosop  : a_nosop;
    assign m_midsop = sel ? g_midsop : a_midsop;

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    src_t srcq [NP][$];
    int   stall [NP];
    exp_t exp_q [$];
    int   out_cyc_q [$];
    int   nosop_cyc_q [$];
    int   nosop_cnt = 0;
    int   onehot_viol = 0;
    bit   busy_hist [1024];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic src_push(input int p, input logic sop, input logic eop, input logic [MW-1:0] mod,
                            input logic [DW-1:0] data, input int gap);
        src_t w;
        w.sop = sop; w.eop = eop; w.mod = mod; w.data = data; w.gap = 8'(gap);
        srcq[p].push_back(w);
    endtask

    task automatic exp_push(input logic sop, input logic eop, input logic [MW-1:0] mod,
                            input logic [DW-1:0] data, input logic [PW-1:0] port, input logic midsop);
        exp_t e;
        e.sop = sop; e.eop = eop; e.mod = mod; e.data = data; e.port = port; e.midsop = midsop;
        exp_q.push_back(e);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NP; i++) if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Begin a test shortly after a rising edge; returns that cycle number.
    task automatic start_test(output int c);
        @(posedge Clk);
        #1;
        c = cyc;
        out_cyc_q.delete();
        nosop_cyc_q.delete();
        nosop_cnt = 0;
        onehot_viol = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #1 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Wait (bounded) until all expected words are seen, sources are empty and the DUT is idle.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !m_busy && src_empty())) begin
            @(negedge Clk);
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: actual=%0d words pending required=0", name, exp_q.size());
                exp_q.delete();
                for (int i = 0; i < NP; i++) srcq[i].delete();
                break;
            end
        end
        repeat (3) @(negedge Clk);
    endtask

    // FWFT source models: present head words at the falling edge, pop just before the rising edge.
    initial begin
        for (int i = 0; i < NP; i++) stall[i] = 0;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < NP; i++) begin
                if (stall[i] > 0) begin
                    Src_DataValid[i] = 1'b0;
                    stall[i]--;
                end else begin
                    Src_DataValid[i] = (srcq[i].size() > 0);
                end
                if (srcq[i].size() > 0) begin
                    Src_DataSop[i]          = srcq[i][0].sop;
                    Src_DataEop[i]          = srcq[i][0].eop;
                    Src_Mod[i*MW +: MW]     = srcq[i][0].mod;
                    Src_Data[i*DW +: DW]    = srcq[i][0].data;
                end else begin
                    Src_DataSop[i]          = 1'b0;
                    Src_DataEop[i]          = 1'b0;
                    Src_Mod[i*MW +: MW]     = '0;
                    Src_Data[i*DW +: DW]    = '0;
                end
            end
            #4;
            if ($countones(m_rd) > 1) onehot_viol++;
            for (int i = 0; i < NP; i++) begin
                if (m_rd[i]) begin
                    if (srcq[i].size() > 0) begin
                        void'(srcq[i].pop_front());
                        stall[i] = (srcq[i].size() > 0) ? int'(srcq[i][0].gap) : 0;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty: actual=read of empty port %0d required=no read", i);
                    end
                end
            end
        end
    end

    // Monitor: compare each output word with the scoreboard head.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                busy_hist[cyc % 1024] = m_busy;
                if (m_valid) begin
                    a.sop = m_sop; a.eop = m_eop; a.mod = m_mod; a.data = m_data;
                    a.port = m_port; a.midsop = m_midsop;
                    out_cyc_q.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: actual=port %0d data %h required=no word", m_port, m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL word: actual=sop%b eop%b mod%0d data%h port%0d mid%b required=sop%b eop%b mod%0d data%h port%0d mid%b",
                                     a.sop, a.eop, a.mod, a.data, a.port, a.midsop,
                                     e.sop, e.eop, e.mod, e.data, e.port, e.midsop);
                        end else begin
                            $display("cycle %0d word port=%0d data=%h sop=%b eop=%b mod=%0d mid=%b",
                                     cyc, a.port, a.data, a.sop, a.eop, a.mod, a.midsop);
                        end
                    end
                end else if (m_midsop) begin
                    checks++;
                    errors++;
                    $display("FAIL midsop_without_word: actual=1 required=0");
                end
                if (m_nosop) begin
                    nosop_cnt++;
                    nosop_cyc_q.push_back(cyc);
                    $display("cycle %0d Err_NoSop pulse", cyc);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Directed tests.
    initial begin
        int c;

        // Reset state.
        #2;
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_read", 64'(a_rd), 64'd0);
        check("rst_port", 64'(a_port), 64'd0);
        check("rst_nosop", 64'(a_nosop), 64'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // T1: single 3-word packet on port 0; Mod forced to 0 on non-Eop words.
        start_test(c);
        src_push(0, 1'b1, 1'b0, 3'd5, 64'hA0, 0);
        src_push(0, 1'b0, 1'b0, 3'd6, 64'hA1, 0);
        src_push(0, 1'b0, 1'b1, 3'd3, 64'hA2, 0);
        exp_push(1'b1, 1'b0, 3'd0, 64'hA0, 2'd0, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'hA1, 2'd0, 1'b0);
        exp_push(1'b0, 1'b1, 3'd3, 64'hA2, 2'd0, 1'b0);
        wait_drain("t1");
        check("t1_words", 64'(out_cyc_q.size()), 64'd3);
        check("t1_sop_latency", 64'(out_cyc_q[0] - c), 64'd2);
        check("t1_eop_latency", 64'(out_cyc_q[2] - c), 64'd4);
        check("t1_busy_c0", 64'(busy_hist[c % 1024]), 64'd0);
        check("t1_busy_c1", 64'(busy_hist[(c + 1) % 1024]), 64'd1);
        check("t1_busy_c4", 64'(busy_hist[(c + 4) % 1024]), 64'd1);
        check("t1_busy_c5", 64'(busy_hist[(c + 5) % 1024]), 64'd0);

        // T2: all ports valid with one-word packets -> order 0,1,2,3,0, spacing 3.
        do_reset();
        start_test(c);
        src_push(0, 1'b1, 1'b1, 3'd1, 64'hB0, 0);
        src_push(0, 1'b1, 1'b1, 3'd5, 64'hB4, 0);
        src_push(1, 1'b1, 1'b1, 3'd2, 64'hB1, 0);
        src_push(2, 1'b1, 1'b1, 3'd3, 64'hB2, 0);
        src_push(3, 1'b1, 1'b1, 3'd4, 64'hB3, 0);
        exp_push(1'b1, 1'b1, 3'd1, 64'hB0, 2'd0, 1'b0);
        exp_push(1'b1, 1'b1, 3'd2, 64'hB1, 2'd1, 1'b0);
        exp_push(1'b1, 1'b1, 3'd3, 64'hB2, 2'd2, 1'b0);
        exp_push(1'b1, 1'b1, 3'd4, 64'hB3, 2'd3, 1'b0);
        exp_push(1'b1, 1'b1, 3'd5, 64'hB4, 2'd0, 1'b0);
        wait_drain("t2");
        check("t2_words", 64'(out_cyc_q.size()), 64'd5);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("t2_spacing_%0d", k), 64'(out_cyc_q[k] - out_cyc_q[k-1]), 64'd3);
        end
        check("t2_onehot_viol", 64'(onehot_viol), 64'd0);

        // T3: port 2 head lacks Sop -> dropped with Err_NoSop, then port 3 served.
        start_test(c);
        src_push(2, 1'b0, 1'b0, 3'd6, 64'hC0, 0);
        src_push(3, 1'b1, 1'b1, 3'd2, 64'hD0, 0);
        exp_push(1'b1, 1'b1, 3'd2, 64'hD0, 2'd3, 1'b0);
        wait_drain("t3");
        check("t3_nosop_count", 64'(nosop_cnt), 64'd1);
        check("t3_nosop_cycle", 64'(nosop_cyc_q[0] - c), 64'd2);
        check("t3_next_sop_cycle", 64'(out_cyc_q[0] - c), 64'd4);

        // T4: port 1 5-word packet with a 4-cycle underrun after word 2; port 2 must wait.
        start_test(c);
        src_push(1, 1'b1, 1'b0, 3'd1, 64'hF0, 0);
        src_push(1, 1'b0, 1'b0, 3'd0, 64'hF1, 0);
        src_push(1, 1'b0, 1'b0, 3'd0, 64'hF2, 0);
        src_push(1, 1'b0, 1'b0, 3'd0, 64'hF3, 4);
        src_push(1, 1'b0, 1'b1, 3'd6, 64'hF4, 0);
        src_push(2, 1'b1, 1'b1, 3'd7, 64'hE0, 0);
        exp_push(1'b1, 1'b0, 3'd0, 64'hF0, 2'd1, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'hF1, 2'd1, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'hF2, 2'd1, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'hF3, 2'd1, 1'b0);
        exp_push(1'b0, 1'b1, 3'd6, 64'hF4, 2'd1, 1'b0);
        exp_push(1'b1, 1'b1, 3'd7, 64'hE0, 2'd2, 1'b0);
        wait_drain("t4");
        check("t4_first_latency", 64'(out_cyc_q[0] - c), 64'd2);
        check("t4_stream_1", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd1);
        check("t4_underrun_gap", 64'(out_cyc_q[3] - out_cyc_q[2]), 64'd5);
        check("t4_stream_2", 64'(out_cyc_q[4] - out_cyc_q[3]), 64'd1);

        // T5: async reset while word 3 of 6 is at the head; stale tail becomes NoSop errors.
        start_test(c);
        src_push(0, 1'b1, 1'b0, 3'd0, 64'h50, 0);
        src_push(0, 1'b0, 1'b0, 3'd0, 64'h51, 0);
        src_push(0, 1'b0, 1'b0, 3'd0, 64'h52, 0);
        src_push(0, 1'b0, 1'b0, 3'd0, 64'h53, 0);
        src_push(0, 1'b0, 1'b0, 3'd0, 64'h54, 0);
        src_push(0, 1'b0, 1'b1, 3'd2, 64'h55, 0);
        exp_push(1'b1, 1'b0, 3'd0, 64'h50, 2'd0, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'h51, 2'd0, 1'b0);
        exp_push(1'b0, 1'b0, 3'd0, 64'h52, 2'd0, 1'b0);
        repeat (5) @(negedge Clk);
        #1 Rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(a_valid), 64'd0);
        check("t5_rst_data", a_data, 64'd0);
        check("t5_rst_busy", 64'(a_busy), 64'd0);
        check("t5_rst_read", 64'(a_rd), 64'd0);
        check("t5_words_left", 64'(srcq[0].size()), 64'd3);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        wait_drain("t5");
        check("t5_nosop_count", 64'(nosop_cnt), 64'd3);
        check("t5_words_out", 64'(out_cyc_q.size()), 64'd3);

        // T6: GAP_CYCLES=0 instance, Sop injected on word 2, second port follows 2 cycles after Eop.
        do_reset();
        sel = 1'b1;
        start_test(c);
        src_push(0, 1'b1, 1'b0, 3'd1, 64'h60, 0);
        src_push(0, 1'b1, 1'b0, 3'd4, 64'h61, 0);
        src_push(0, 1'b0, 1'b1, 3'd7, 64'h62, 0);
        src_push(1, 1'b1, 1'b1, 3'd2, 64'h70, 0);
        exp_push(1'b1, 1'b0, 3'd0, 64'h60, 2'd0, 1'b0);
        exp_push(1'b1, 1'b0, 3'd0, 64'h61, 2'd0, 1'b1);
        exp_push(1'b0, 1'b1, 3'd7, 64'h62, 2'd0, 1'b0);
        exp_push(1'b1, 1'b1, 3'd2, 64'h70, 2'd1, 1'b0);
        wait_drain("t6");
        check("t6_first_latency", 64'(out_cyc_q[0] - c), 64'd2);
        check("t6_eop_to_sop", 64'(out_cyc_q[3] - out_cyc_q[2]), 64'd2);
        check("t6_onehot_viol", 64'(onehot_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
